// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: valid/ready handshake, flush-to-bubble,
// optional one-entry skid buffer and a saturating stall-cycle counter.
module pipe_stage_reg #(
  parameter int DATA_W = 128,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_occupancy,
  output logic [CNT_W-1:0]  o_stall_cnt,
  input  logic              i_cnt_clr
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            state_p0, state_nxt;
  logic [DATA_W-1:0] main_p0, main_nxt;
  logic [DATA_W-1:0] skid_p0, skid_nxt;
  logic [CNT_W-1:0]  stall_cnt_p0, stall_cnt_nxt;
  logic              accept, take;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + CNT_W'(1);
  endfunction

  // With the skid buffer, ready depends on the state register alone so the
  // downstream stall never reaches the upstream stage in the same cycle.
  if (SKID != 0) begin : g_skid
    assign o_ready = (state_p0 != ST_TWO);
  end else begin : g_noskid
    assign o_ready = (state_p0 == ST_EMPTY) | i_ready;
  end

  assign o_valid     = (state_p0 != ST_EMPTY);
  assign o_data      = main_p0;
  assign o_occupancy = {state_p0 == ST_TWO, state_p0 == ST_ONE};
  assign o_stall_cnt = stall_cnt_p0;
  assign accept      = i_valid & o_ready;
  assign take        = o_valid & i_ready;

  always_comb begin
    state_nxt = state_p0;
    main_nxt  = main_p0;
    skid_nxt  = skid_p0;
    if (i_flush) begin
      state_nxt = ST_EMPTY;
      main_nxt  = '0;
      skid_nxt  = '0;
    end else begin
      case (state_p0)
        ST_EMPTY: begin
          if (accept) begin
            state_nxt = ST_ONE;
            main_nxt  = i_data;
          end
        end
        ST_ONE: begin
          if (accept && take) begin
            main_nxt = i_data;
          end else if (accept && (SKID != 0)) begin
            state_nxt = ST_TWO;
            skid_nxt  = i_data;
          end else if (take) begin
            state_nxt = ST_EMPTY;
            main_nxt  = '0;
          end
        end
        ST_TWO: begin
          if (take) begin
            state_nxt = ST_ONE;
            main_nxt  = skid_p0;
            skid_nxt  = '0;
          end
        end
        default: begin
          state_nxt = ST_EMPTY;
          main_nxt  = '0;
          skid_nxt  = '0;
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_nxt = stall_cnt_p0;
    if (i_cnt_clr) begin
      stall_cnt_nxt = '0;
    end else if (o_valid && !i_ready) begin
      stall_cnt_nxt = sat_inc(stall_cnt_p0);
    end
  end

  // Stage boundary: payload bubbles to zero so o_data is clean when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0     <= ST_EMPTY;
      main_p0      <= '0;
      skid_p0      <= '0;
      stall_cnt_p0 <= '0;
    end else begin
      state_p0     <= state_nxt;
      main_p0      <= main_nxt;
      skid_p0      <= skid_nxt;
      stall_cnt_p0 <= stall_cnt_nxt;
    end
  end

endmodule
